m_display_write_pacer: RTL and testbench
========================================

// Module: m_display_write_pacer
// PURPOSE
//  Upstream feeder for the S1 7-segment display stage. Snoops the register-file write-back port,
//  captures writes to one watched register into a small FIFO, and replays each value as a
//  one-cycle write_reg/write_data pulse spaced HOLD_CYCLES apart, so bursts stay human-readable.
//  Outputs connect directly to the display stage's write_reg/write_data inputs.
// PARAMETERS
//  WATCH_REG    5'd17  register index to capture (S1); WATCH_REG==0 means nothing is ever captured
//  DEPTH        4      FIFO entries, power of 2, >=2
//  HOLD_CYCLES  8      idle cycles after each pulse, >=1 (use ~50_000_000 on board)
// PORTS
//  clk             in   1   single clock; all state on posedge
//  rst_n           in   1   asynchronous active-low reset
//  reg_write       in   1   register-file write enable
//  wb_reg          in   5   write-back destination register
//  wb_data         in   32  write-back data
//  out_write_reg   out  5   WATCH_REG during a release pulse, else 5'd0
//  out_write_data  out  32  last released value; held between pulses
//  busy            out  1   FSM not in IDLE, or FIFO non-empty
//  fifo_count      out  $clog2(DEPTH)+1  current occupancy
//  overflow        out  1   sticky; set on the first lost value
//  dropped_cnt     out  8   lost values; saturates at 255
// BEHAVIOUR
//  - Reset: FIFO empty, FSM=IDLE, hold counter=0, every output 0. Takes effect immediately,
//    including mid-HOLD with entries queued; all queued data is discarded.
//  - Capture: reg_write && wb_reg==WATCH_REG && wb_reg!=0, sampled on posedge; pushed that edge.
//  - FSM (registered):
//    IDLE: if fifo_count>0, pop -> SHOW. Output registered the same edge.
//    SHOW: exactly one cycle. out_write_reg=WATCH_REG; out_write_data=popped value -> HOLD.
//      The counter loads HOLD_CYCLES.
//    HOLD: out_write_reg=0; counter decrements each cycle. At the edge where it reaches 1:
//      pop -> SHOW if non-empty, else -> IDLE.
//  - Timing:
//    - Latency from capture cycle (empty FIFO, IDLE) to pulse: 2 cycles.
//    - Back-to-back pulses are exactly HOLD_CYCLES+1 cycles apart.
//  - Push+pop same edge: both occur. A full FIFO with a simultaneous pop accepts the push;
//    there is no overflow in that case.
//  - Full FIFO without a pop: see CONFIGURATION. overflow<=1 and dropped_cnt++ (saturating)
//    in both modes.
//  - FIFO pointers: $clog2(DEPTH) bits, natural wrap; count = pushes-pops, never >DEPTH.
//  - The display samples on negedge. Outputs change only on posedge, so they are stable
//    across the sampling negedge.
// CONFIGURATION
//  DISP_PACER_COALESCE_EN defined:
//    - Push to a full FIFO with no pop overwrites the newest entry; the most recent value is
//      always shown.
//  Not defined:
//    - The incoming value is dropped and FIFO contents are unchanged.
// TESTING
//  1) Write x17=0x00123456 once, FSM idle
//     -> 2 cycles later a single-cycle out_write_reg=17, out_write_data=0x00123456;
//        data holds afterward.
//  2) Writes to x5 and x0, reg_write=0 with wb_reg=17
//     -> fifo_count stays 0, no pulse, busy=0.
//  3) Back-to-back x17 writes A,B,C (HOLD=8)
//     -> pulses A,B,C in order, 9 cycles apart; busy drops the cycle after C's HOLD ends.
//  4) Six back-to-back x17 writes A..F (DEPTH=4)
//     -> without macro: shown A,B,C,D,E; overflow=1, dropped_cnt=1.
//     -> with DISP_PACER_COALESCE_EN: shown A,B,C,D,F; overflow=1, dropped_cnt=1.
//  5) 300 writes, one per cycle
//     -> dropped_cnt saturates at 255; fifo_count never exceeds 4.
//  6) Assert rst_n mid-HOLD with 2 queued, then release
//     -> outputs 0 immediately; no pulse until a new x17 write, which appears 2 cycles
//        after capture.

Source files
------------

// File: rtl/m_display_write_pacer.sv
// -----------------------------------------------------------------------------
// m_display_write_pacer
//
// Upstream feeder for the S1 7-segment display stage. It snoops the
// register-file write-back port, queues every write to WATCH_REG in a small
// FIFO and replays each queued value as a single-cycle write_reg/write_data
// pulse. Pulses are spaced HOLD_CYCLES idle cycles apart so that bursts of
// writes stay readable on the display.
//
// Optional feature (compile-time macro):
//   DISP_PACER_COALESCE_EN  - when defined, a write arriving while the FIFO is
//                             full (and nothing is popped that edge) overwrites
//                             the newest queued entry instead of being dropped.
//
// Parameters:
//   WATCH_REG    register index to capture; 0 disables capture entirely
//   DEPTH        FIFO entries (power of 2, >= 2)
//   HOLD_CYCLES  idle cycles after each pulse (>= 1)
//
// Ports:
//   clk             in   single clock, all state on posedge
//   rst_n           in   asynchronous active-low reset
//   reg_write       in   register-file write enable
//   wb_reg          in   write-back destination register
//   wb_data         in   write-back data
//   out_write_reg   out  WATCH_REG during a release pulse, else 0
//   out_write_data  out  last released value, held between pulses
//   busy            out  pacer not idle or FIFO non-empty
//   fifo_count      out  current FIFO occupancy
//   overflow        out  sticky, set on the first lost value
//   dropped_cnt     out  lost values, saturating at 255
// -----------------------------------------------------------------------------
module m_display_write_pacer #(
    parameter logic [4:0]  WATCH_REG   = 5'd17,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     reg_write,
    input  logic [4:0]               wb_reg,
    input  logic [31:0]              wb_data,
    output logic [4:0]               out_write_reg,
    output logic [31:0]              out_write_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               dropped_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   hold_q, hold_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [31:0]     mem_q [DEPTH];
    logic [4:0]      out_reg_q, out_reg_d;
    logic [31:0]     out_data_q, out_data_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      dropped_q, dropped_d;

    logic            capture;
    logic            full;
    logic            non_empty;
    logic            pop;
    logic            push_ok;
    logic            lost;
    logic [AW-1:0]   newest_ptr;

    // A capture needs a real write to the watched register; x0 is never watched.
    assign capture    = reg_write && (wb_reg == WATCH_REG) && (wb_reg != 5'd0);
    assign full       = (count_q == FULL_COUNT);
    assign non_empty  = (count_q != '0);
    // A pop frees a slot on the same edge, so a full FIFO can still take a push.
    assign push_ok    = capture && (!full || pop);
    assign lost       = capture && full && !pop;
    assign newest_ptr = wr_ptr_q - PTR_ONE;

    // State register: FSM, hold counter, FIFO pointers and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            out_reg_q  <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            out_reg_q  <= out_reg_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    // FIFO storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wb_data;
        end
`ifdef DISP_PACER_COALESCE_EN
        else if (lost) begin
            mem_q[newest_ptr] <= wb_data;
        end
`endif
    end

    // Next-state logic: a pop happens from IDLE whenever data is waiting, or at
    // the final HOLD cycle (counter at 1) if more data is queued.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (non_empty) begin
                    pop     = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_q == HOLD_ONE) begin
                    if (non_empty) begin
                        pop     = 1'b1;
                        state_d = SHOW;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs, hold counter, FIFO
    // bookkeeping and the loss statistics.
    always_comb begin
        out_reg_d  = (state_d == SHOW) ? WATCH_REG : 5'd0;
        out_data_d = pop ? mem_q[rd_ptr_q] : out_data_q;

        hold_d = hold_q;
        if (state_q == SHOW) begin
            hold_d = HOLD_LOAD;
        end else if (state_q == HOLD) begin
            hold_d = hold_q - HOLD_ONE;
        end

        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + COUNT_ONE;
        end else if (pop && !push_ok) begin
            count_d = count_q - COUNT_ONE;
        end

        overflow_d = overflow_q | lost;
        dropped_d  = dropped_q;
        if (lost && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    assign out_write_reg  = out_reg_q;
    assign out_write_data = out_data_q;
    assign busy           = (state_q != IDLE) || non_empty;
    assign fifo_count     = count_q;
    assign overflow       = overflow_q;
    assign dropped_cnt    = dropped_q;

endmodule

// File: tb/tb_m_display_write_pacer.sv
// -----------------------------------------------------------------------------
// tb_m_display_write_pacer
//
// Self-checking bench for m_display_write_pacer. A queue-and-timestamp model
// predicts every output after each clock edge: a queued value may be released
// at the first edge at or after the next free release slot, and each release
// reserves the following HOLD+1 edges.
// -----------------------------------------------------------------------------
module tb_m_display_write_pacer;

    localparam int          DEPTH = 4;
    localparam int          HOLD  = 8;
    localparam logic [4:0]  WATCH = 5'd17;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [4:0]  out_write_reg;
    logic [31:0] out_write_data;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [7:0]  dropped_cnt;

    int nAsserts = 0;
    int nFails   = 0;

    // Reference model state
    logic [31:0] modelQ[$];
    longint      edgeNum  = 0;
    longint      nextSlot = 0;
    logic [4:0]  expReg   = '0;
    logic [31:0] expData  = '0;
    logic        expOvf   = 1'b0;
    int          expDrop  = 0;

    m_display_write_pacer #(
        .WATCH_REG   (WATCH),
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .reg_write      (reg_write),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data),
        .out_write_reg  (out_write_reg),
        .out_write_data (out_write_data),
        .busy           (busy),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .dropped_cnt    (dropped_cnt)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report a failure with observed/expected.
    task checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model's prediction.
    task checkOutput(input string phase);
        checkVal({phase, ".out_write_reg"},  32'(out_write_reg),  32'(expReg));
        checkVal({phase, ".out_write_data"}, out_write_data,      expData);
        checkVal({phase, ".fifo_count"},     32'(fifo_count),     32'(modelQ.size()));
        checkVal({phase, ".busy"},           32'(busy),
                 32'((modelQ.size() > 0) || (edgeNum < nextSlot)));
        checkVal({phase, ".overflow"},       32'(overflow),       32'(expOvf));
        checkVal({phase, ".dropped_cnt"},    32'(dropped_cnt),    32'(expDrop));
    endtask

    // Model of one clock edge: release first (using the queue as it stood
    // before this edge), then accept or lose the incoming write.
    task modelEdge(input logic wr, input logic [4:0] r, input logic [31:0] d);
        edgeNum++;
        expReg = 5'd0;
        if (modelQ.size() > 0 && edgeNum >= nextSlot) begin
            expData  = modelQ.pop_front();
            expReg   = WATCH;
            nextSlot = edgeNum + HOLD + 1;
        end
        if (wr && r == WATCH && r != 5'd0) begin
            if (modelQ.size() < DEPTH) begin
                modelQ.push_back(d);
            end else begin
                expOvf = 1'b1;
                if (expDrop < 255) expDrop++;
`ifdef DISP_PACER_COALESCE_EN
                modelQ[modelQ.size() - 1] = d;
`endif
            end
        end
    endtask

    // Drive one cycle of write-back traffic, advance a clock edge, then check.
    task applyStimulus(input logic wr, input logic [4:0] r, input logic [31:0] d, input string phase);
        reg_write = wr;
        wb_reg    = r;
        wb_data   = d;
        @(posedge clk);
        modelEdge(wr, r, d);
        #1;
        checkOutput(phase);
    endtask

    task idleCycles(input int n, input string phase);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'h0, phase);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task applyReset(input string phase);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        modelQ.delete();
        nextSlot = 0;
        expReg   = '0;
        expData  = '0;
        expOvf   = 1'b0;
        expDrop  = 0;
        #1;
        checkOutput(phase);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        edgeNum++;
        #1;
        checkOutput({phase, "_released"});
    endtask

    initial begin
        rst_n     = 1'b1;
        reg_write = 1'b0;
        wb_reg    = 5'd0;
        wb_data   = 32'h0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        edgeNum++;
        #1;
        checkOutput("reset_released");

        // 1) Single capture: pulse two cycles after the capture cycle, data held.
        applyStimulus(1'b1, 5'd17, 32'h00123456, "s1");
        applyStimulus(1'b0, 5'd0, 32'h0, "s1");
        checkVal("s1_pulse_reg", 32'(out_write_reg), 32'd17);
        checkVal("s1_pulse_data", out_write_data, 32'h00123456);
        idleCycles(12, "s1_hold");
        checkVal("s1_data_held", out_write_data, 32'h00123456);

        // 2) Writes that must not be captured.
        applyStimulus(1'b1, 5'd5,  32'hDEADBEEF, "s2");
        applyStimulus(1'b1, 5'd0,  32'hCAFEF00D, "s2");
        applyStimulus(1'b0, 5'd17, 32'h0BADF00D, "s2");
        idleCycles(3, "s2");
        checkVal("s2_busy", 32'(busy), 32'd0);

        // 3) Three back-to-back captures, pulses HOLD+1 apart.
        applyStimulus(1'b1, 5'd17, 32'hAAAA0001, "s3");
        applyStimulus(1'b1, 5'd17, 32'hAAAA0002, "s3");
        applyStimulus(1'b1, 5'd17, 32'hAAAA0003, "s3");
        idleCycles(32, "s3_drain");

        // 4) Six back-to-back captures overrun the FIFO by one.
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 5'd17, 32'hB0000000 + 32'(i), "s4");
        idleCycles(50, "s4_drain");
        checkVal("s4_overflow", 32'(overflow), 32'd1);
        checkVal("s4_dropped", 32'(dropped_cnt), 32'd1);
`ifdef DISP_PACER_COALESCE_EN
        checkVal("s4_last_shown", out_write_data, 32'hB0000005);
`else
        checkVal("s4_last_shown", out_write_data, 32'hB0000004);
`endif

        // 5) Long burst: drop counter saturates, occupancy stays bounded.
        for (int i = 0; i < 300; i++)
            applyStimulus(1'b1, 5'd17, $urandom, "s5");
        checkVal("s5_dropped_sat", 32'(dropped_cnt), 32'd255);
        idleCycles(50, "s5_drain");

        // 6) Reset mid-HOLD with entries queued, then a fresh capture.
        applyReset("s6_pre");
        applyStimulus(1'b1, 5'd17, 32'hC0000001, "s6");
        applyStimulus(1'b1, 5'd17, 32'hC0000002, "s6");
        applyStimulus(1'b1, 5'd17, 32'hC0000003, "s6");
        idleCycles(3, "s6");
        applyReset("s6_reset");
        idleCycles(12, "s6_quiet");
        applyStimulus(1'b1, 5'd17, 32'hC0FFEE00, "s6_new");
        applyStimulus(1'b0, 5'd0, 32'h0, "s6_new");
        checkVal("s6_new_pulse_data", out_write_data, 32'hC0FFEE00);

        // Random traffic mixing watched, unwatched and x0 writes.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] r;
            case ($urandom_range(0, 3))
                0:       r = 5'd0;
                1:       r = 5'($urandom_range(1, 31));
                default: r = 5'd17;
            endcase
            applyStimulus(1'($urandom_range(0, 2) == 0), r, $urandom, "rand");
        end
        idleCycles(60, "rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
